// File: rtl/btn_debounce.sv
//==============================================================================
// Module   : btn_debounce
// Purpose  : Push-button front end: 2-flop synchroniser, counter-qualified
//            debounce FSM, registered clean level output.
// Options  : BTN_DEBOUNCE_EDGE_EN adds one-cycle rise/fall pulses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_stable,
   output logic btn_rise,
   output logic btn_fall
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   sync1_q, sync2_q;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   stable_q, stable_d;

   // btn_raw is asynchronous; only sync2_q may be used downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_LOW;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   // cnt_d defaults to zero so the counter is cleared on every state change
   // and held at zero in the settled states.
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      stable_d = stable_q;
      case (state_q)
         S_LOW: begin
            if (sync2_q) begin
               state_d = S_RISE;
            end
         end
         S_RISE: begin
            if (!sync2_q) begin
               state_d = S_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_HIGH;
               stable_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         S_HIGH: begin
            if (!sync2_q) begin
               state_d = S_FALL;
            end
         end
         S_FALL: begin
            if (sync2_q) begin
               state_d = S_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_LOW;
               stable_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d  = S_LOW;
            stable_d = 1'b0;
         end
      endcase
   end

   assign btn_stable = stable_q;

`ifdef BTN_DEBOUNCE_EDGE_EN
   logic rise_q, fall_q;

   // Pulses are registered from the same next-state term as stable_q so they
   // coincide exactly with the level change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= stable_d & ~stable_q;
         fall_q <= ~stable_d & stable_q;
      end
   end

   assign btn_rise = rise_q;
   assign btn_fall = fall_q;
`else
   assign btn_rise = 1'b0;
   assign btn_fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
//==============================================================================
// Module   : tb_btn_debounce
// Purpose  : Self-checking bench for btn_debounce (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_btn_debounce;

   localparam int D = 4;
   localparam int W = 3;
`ifdef BTN_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic btn_raw;
   logic btn_stable;
   logic btn_rise;
   logic btn_fall;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: two-sample delay, then the output flips once the delayed
   // input has disagreed with it for D+1 consecutive samples.
   logic m_s1, m_s2, m_stable, m_rise, m_fall;
   int   m_run;

   btn_debounce #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .btn_stable (btn_stable),
      .btn_rise   (btn_rise),
      .btn_fall   (btn_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_rise = 0; m_fall = 0; m_run = 0;
   endtask

   task automatic model_edge(input logic raw);
      logic sync;
      sync   = m_s2;
      m_rise = 0;
      m_fall = 0;
      if (sync != m_stable) begin
         m_run++;
         if (m_run == D + 1) begin
            m_stable = sync;
            m_run    = 0;
            m_rise   = EDGE_EN & sync;
            m_fall   = EDGE_EN & ~sync;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   // Drive raw, advance one edge, leave time at edge+1 for sampling.
   task automatic step(input logic raw);
      btn_raw = raw;
      @(posedge clk);
      if (rst_n) model_edge(raw);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn_raw = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         n_checks++;
         if ({btn_stable, btn_rise, btn_fall} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_hold: got stable/rise/fall=%b expected 000", {btn_stable, btn_rise, btn_fall});
         end
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1'b0);
         n_checks++;
         if ({btn_stable, btn_rise, btn_fall} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_release: cycle %0d got %b expected 000", i, {btn_stable, btn_rise, btn_fall});
         end
      end
   endtask

   task automatic test_clean_press();
      int first_hi = -1;
      int rise_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1);
         n_checks++;
         if (btn_stable !== m_stable || btn_rise !== m_rise) begin
            n_errors++;
            $display("FAIL press_model: edge %0d got stable=%b rise=%b expected %b %b", i, btn_stable, btn_rise, m_stable, m_rise);
         end
         if (btn_stable === 1'b1 && first_hi < 0) first_hi = i;
         if (btn_rise === 1'b1) rise_cnt++;
      end
      n_checks++;
      if (first_hi != 6) begin
         n_errors++;
         $display("FAIL press_latency: got edge %0d expected 6", first_hi);
      end
      n_checks++;
      if (rise_cnt != int'(EDGE_EN)) begin
         n_errors++;
         $display("FAIL press_rise_pulses: got %0d expected %0d", rise_cnt, int'(EDGE_EN));
      end
   endtask

   task automatic test_clean_release();
      int first_lo = -1;
      int fall_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0);
         n_checks++;
         if (btn_stable !== m_stable || btn_fall !== m_fall) begin
            n_errors++;
            $display("FAIL release_model: edge %0d got stable=%b fall=%b expected %b %b", i, btn_stable, btn_fall, m_stable, m_fall);
         end
         if (btn_stable === 1'b0 && first_lo < 0) first_lo = i;
         if (btn_fall === 1'b1) fall_cnt++;
      end
      n_checks++;
      if (first_lo != 6) begin
         n_errors++;
         $display("FAIL release_latency: got edge %0d expected 6", first_lo);
      end
      n_checks++;
      if (fall_cnt != int'(EDGE_EN)) begin
         n_errors++;
         $display("FAIL release_fall_pulses: got %0d expected %0d", fall_cnt, int'(EDGE_EN));
      end
   endtask

   task automatic test_bounce();
      logic pattern [16];
      for (int i = 0; i < 16; i++) pattern[i] = (i < 3) || (i >= 4 && i < 6);
      for (int i = 0; i < 16; i++) begin
         step(pattern[i]);
         n_checks++;
         if (btn_stable !== 1'b0 || btn_rise !== 1'b0 || btn_stable !== m_stable) begin
            n_errors++;
            $display("FAIL bounce_reject: step %0d got stable=%b rise=%b expected 0 0", i, btn_stable, btn_rise);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      int first_hi = -1;
      for (int i = 0; i < 5; i++) step(1'b1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (btn_stable !== 1'b0 || dut.cnt_q !== 3'd0) begin
         n_errors++;
         $display("FAIL mid_press_reset: got stable=%b cnt=%0d expected 0 0", btn_stable, dut.cnt_q);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1);
         n_checks++;
         if (btn_stable !== m_stable) begin
            n_errors++;
            $display("FAIL mid_press_model: edge %0d got %b expected %b", i, btn_stable, m_stable);
         end
         if (btn_stable === 1'b1 && first_hi < 0) first_hi = i;
      end
      n_checks++;
      if (first_hi != 6) begin
         n_errors++;
         $display("FAIL mid_press_latency: got edge %0d expected 6", first_hi);
      end
   endtask

   task automatic test_release_bounce();
      for (int i = 0; i < 15; i++) begin
         step(i < 3 ? 1'b0 : 1'b1);
         n_checks++;
         if (btn_stable !== 1'b1 || btn_fall !== 1'b0) begin
            n_errors++;
            $display("FAIL release_bounce: step %0d got stable=%b fall=%b expected 1 0", i, btn_stable, btn_fall);
         end
      end
   endtask

   task automatic test_random();
      logic lvl = 1'b0;
      int   run;
      for (int i = 0; i < 600; ) begin
         run = $urandom_range(1, 9);
         lvl = ~lvl;
         for (int k = 0; k < run; k++) begin
            step(lvl);
            i++;
            n_checks++;
            if (btn_stable !== m_stable || btn_rise !== m_rise || btn_fall !== m_fall) begin
               n_errors++;
               $display("FAIL random: cycle %0d got s/r/f=%b%b%b expected %b%b%b", i, btn_stable, btn_rise, btn_fall, m_stable, m_rise, m_fall);
            end
            if ($urandom_range(0, 199) == 0) begin
               #2 rst_n = 1'b0;
               model_reset();
               #1;
               n_checks++;
               if ({btn_stable, btn_rise, btn_fall} !== 3'b000) begin
                  n_errors++;
                  $display("FAIL random_reset: got %b expected 000", {btn_stable, btn_rise, btn_fall});
               end
               #1 rst_n = 1'b1;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_clean_release();
      test_bounce();
      test_reset_mid_press();
      test_release_bounce();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Fast-clock front end for each push button: synchronises the raw asynchronous pin, filters contact bounce with a counter-qualified FSM, and drives a clean level `btn_stable`.
- `btn_stable` feeds the 2 Hz button-pulse synchroniser and the ping-pong FSM.
- Runs on the board system clock. One instance per button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive fast-clock cycles the synchronised input must hold a new level before `btn_stable` follows (10 ms at 100 MHz). Legal range ≥1.
- CNT_WIDTH, 20, counter width. Must satisfy 2^CNT_WIDTH ≥ DEBOUNCE_CYCLES.

Ports:
- clk  input  1  fast system clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw button pin, asynchronous to clk, may bounce.
- btn_stable  output  1  debounced level, registered.
- btn_rise  output  1  one-cycle pulse on `btn_stable` 0→1. Active only with BTN_DEBOUNCE_EDGE_EN.
- btn_fall  output  1  one-cycle pulse on `btn_stable` 1→0. Active only with BTN_DEBOUNCE_EDGE_EN.

Behaviour:
- Reset:
  - One clock (`clk`). `rst_n` is asynchronous, active-low; asserting it clears all state immediately, independent of `clk`.
  - Reset values: sync_ff1=0, sync_ff2=0, cnt=0, state=S_LOW, btn_stable=0, btn_rise=0, btn_fall=0.
- Synchroniser:
  - btn_raw → sync_ff1 → sync_ff2 (two flops).
  - FSM sees only `sync = sync_ff2`.
  - No other logic touches `btn_raw`.
- FSM states: S_LOW, S_RISE, S_HIGH, S_FALL.
- S_LOW (btn_stable=0):
  - sync=1 → S_RISE, cnt←0.
  - Otherwise stay.
- S_RISE:
  - sync=0 → S_LOW, cnt←0. Bounce rejected; btn_stable unchanged.
  - sync=1 and cnt==DEBOUNCE_CYCLES-1 → S_HIGH, btn_stable←1.
  - sync=1 otherwise → cnt←cnt+1.
- S_HIGH (btn_stable=1):
  - sync=0 → S_FALL, cnt←0.
  - Otherwise stay.
- S_FALL:
  - Mirror of S_RISE.
  - sync=1 → S_HIGH, cnt←0.
  - sync=0 and cnt==DEBOUNCE_CYCLES-1 → S_LOW, btn_stable←0.
  - sync=0 otherwise → cnt←cnt+1.
- Latency:
  - `btn_raw` changes and stays steady before rising edge E0.
  - `btn_stable` changes on edge E(DEBOUNCE_CYCLES+2), i.e. DEBOUNCE_CYCLES+3 edges after the change.
  - Latency is identical for press and release.
- Counter:
  - Compare is equality only; cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - cnt is held at 0 in S_LOW and S_HIGH.
- Any opposite-level sample during S_RISE/S_FALL restarts qualification from zero. A pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation never reaches `btn_stable`.
- `btn_raw` held high through reset: after release, the normal press qualification applies. `btn_stable` rises DEBOUNCE_CYCLES+3 edges after the first edge following deassertion.
- Reset mid-qualification: count is discarded; `btn_stable` returns to 0 immediately.
- DEBOUNCE_CYCLES=1: the transition happens on the first edge in S_RISE/S_FALL. Latency is 4 edges.

Optional Feature:
- Macro: BTN_DEBOUNCE_EDGE_EN.
- Defined:
  - `btn_rise` is registered high for exactly one clk cycle, on the same edge `btn_stable` goes 0→1.
  - `btn_fall` is registered high for exactly one clk cycle, on the same edge `btn_stable` goes 1→0.
  - Both are 0 in every other cycle and during reset.
- Undefined:
  - `btn_rise` and `btn_fall` remain ports but are tied constant 0.
  - No edge-pulse flops are generated.
  - `btn_stable` behaviour is unchanged.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
- Reset: rst_n=0 with btn_raw=1, then release with btn_raw=0 held 20 cycles → btn_stable=0, btn_rise=0 and btn_fall=0 throughout.
- Clean press: btn_raw 0→1 before edge E0, held → btn_stable=1 first after E6, never earlier. With EDGE_EN, btn_rise=1 for exactly the cycle after E6.
- Bounce rejection: btn_raw high 3 cycles, low 1, high 2, low 10 → btn_stable stays 0 and btn_rise never asserts.
- Clean release: from btn_stable=1, btn_raw 1→0 held → btn_stable=0 after edge E6 of the release. With EDGE_EN, btn_fall is a single-cycle pulse; with the macro undefined, btn_fall stays 0.
- Reset mid-qualification, press: btn_raw high, rst_n pulsed low asynchronously (mid-cycle) 5 edges into the press → btn_stable and cnt clear immediately. With btn_raw still high, btn_stable rises 7 edges after the first edge post-release.
- Reset mid-qualification, release bounce: from btn_stable=1, btn_raw low for 3 cycles then high → btn_stable stays 1 and no btn_fall pulse.
